// File: rtl/clint_axi_slave_pkg.sv
// Shared definitions for the CLINT slave: response codes, register offsets,
// FSM state types and small decode/merge helpers.
package clint_axi_slave_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
  localparam logic [31:0] CLINT_BASE         = 32'h0200_0000;

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  typedef enum logic [2:0] {
    REG_MSIP, REG_CMP_LO, REG_CMP_HI, REG_MTIME_LO, REG_MTIME_HI, REG_NONE
  } reg_sel_t;

  typedef struct packed {
    r_state_t r_state;
    w_state_t w_state;
  } clint_dbg_t;

  // Word offset decode; the base and byte-lane bits are never looked at.
  function automatic reg_sel_t decode_off(input logic [15:2] off);
    case (off)
      CLINT_MSIP_OFF[15:2]:              decode_off = REG_MSIP;
      CLINT_MTIMECMP_OFF[15:2]:          decode_off = REG_CMP_LO;
      CLINT_MTIMECMP_OFF[15:2] + 14'd1:  decode_off = REG_CMP_HI;
      CLINT_MTIME_OFF[15:2]:             decode_off = REG_MTIME_LO;
      CLINT_MTIME_OFF[15:2] + 14'd1:     decode_off = REG_MTIME_HI;
      default:                           decode_off = REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    merge_bytes = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) merge_bytes[8*i +: 8] = new_val[8*i +: 8];
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Free-running 64-bit mtime with a TICK_DIV prescaler and byte-strobed
// writes to either half; a write in a tick cycle wins over the increment.
module clint_mtime_counter
  import clint_axi_slave_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrob,
  output logic [63:0] mtime
);

  logic [15:0] presc;
  logic        tick;

  assign tick = (presc == 16'(TICK_DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) presc <= '0;
    else            presc <= tick ? '0 : presc + 16'd1;
  end

  // Halves are written independently, so no carry crosses on a write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  mtime <= '0;
    else if (wr_lo)  mtime[31:0]  <= merge_bytes(mtime[31:0], wdata, wstrob);
    else if (wr_hi)  mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wstrob);
    else if (tick)   mtime <= mtime + 64'd1;
  end

endmodule

// File: rtl/clint_axi_slave.sv
// CLINT register block on an AXI-lite-style slave port: msip, mtimecmp,
// mtime, with independent read and write channel FSMs and a registered mtip.
module clint_axi_slave
  import clint_axi_slave_pkg::*;
#(
  parameter int unsigned DATA_LEN       = 32,
  parameter int unsigned DATA_STROB_LEN = DATA_LEN / 8,
  parameter int unsigned TICK_DIV       = 1
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_LEN-1:0]       waddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_LEN-1:0]       wdata,
  input  logic [DATA_STROB_LEN-1:0] wstrob,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [2:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [DATA_LEN-1:0]       raddr,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_LEN-1:0]       rdata,
  output logic [2:0]                rresp,
  output logic                      mtip,
  output logic                      msip
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both high; the sender holds its payload stable
  // from raising valid until that edge.

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  clint_dbg_t dbg;

  logic                      aw_held, w_held, commit, wr_en;
  logic [15:2]               waddr_q;
  logic [DATA_LEN-1:0]       wdata_q;
  logic [DATA_STROB_LEN-1:0] wstrob_q;
  reg_sel_t                  wsel, rsel;
  logic [63:0]               mtime, mtimecmp;
  logic                      msip_q;
  logic [DATA_LEN-1:0]       rd_val;
  logic [2:0]                rd_resp;
  logic                      unused_bits;

  assign dbg         = '{r_state: r_state, w_state: w_state};
  assign unused_bits = ^{waddr[DATA_LEN-1:16], waddr[1:0],
                         raddr[DATA_LEN-1:16], raddr[1:0], dbg};

  assign awready = (w_state == W_IDLE) && !aw_held;
  assign wready  = (w_state == W_IDLE) && !w_held;
  assign bvalid  = (w_state == W_RESP);
  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign msip    = msip_q;

  assign commit = (w_state == W_IDLE) && aw_held && w_held;
  assign wsel   = decode_off(waddr_q);
  assign wr_en  = commit && (|wstrob_q);
  assign rsel   = decode_off(raddr[15:2]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (commit) w_next = W_RESP;
      W_RESP: if (bready) w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (arvalid) r_next = R_RESP;
      R_RESP: if (rready)  r_next = R_IDLE;
    endcase
  end

  // AW and W are captured independently; both flags clear when B completes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrob_q <= '0;
    end else if (bvalid && bready) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        waddr_q <= waddr[15:2];
      end
      if (wvalid && wready) begin
        w_held   <= 1'b1;
        wdata_q  <= wdata;
        wstrob_q <= wstrob;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  bresp <= RESP_OKAY;
    else if (commit) bresp <= (wsel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      msip_q   <= 1'b0;
      mtimecmp <= '1;
    end else if (wr_en) begin
      if (wsel == REG_MSIP && wstrob_q[0]) msip_q <= wdata_q[0];
      if (wsel == REG_CMP_LO)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wdata_q, wstrob_q);
      if (wsel == REG_CMP_HI)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata_q, wstrob_q);
    end
  end

  clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_mtime (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_lo     (wr_en && (wsel == REG_MTIME_LO)),
    .wr_hi     (wr_en && (wsel == REG_MTIME_HI)),
    .wdata     (wdata_q),
    .wstrob    (wstrob_q),
    .mtime     (mtime)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) mtip <= 1'b0;
    else            mtip <= (mtime >= mtimecmp);
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rsel)
      REG_MSIP:     rd_val = {31'd0, msip_q};
      REG_CMP_LO:   rd_val = mtimecmp[31:0];
      REG_CMP_HI:   rd_val = mtimecmp[63:32];
      REG_MTIME_LO: rd_val = mtime[31:0];
      REG_MTIME_HI: rd_val = mtime[63:32];
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  // Sampled from the pre-edge registers, so a same-cycle commit is not seen.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rdata <= rd_val;
      rresp <= rd_resp;
    end
  end

endmodule
